// File: rtl/ibexc_dbus_arbiter_if.sv
// ibexc_dbus_arbiter_if: host-side and shared memory-side data bus of the
// N-port data-bus arbiter, bundled so the arbiter takes a single bus port.
interface ibexc_dbus_arbiter_if #(
  parameter int unsigned NumHarts  = 2,
  parameter int unsigned DataWidth = 33
);
  // Per-hart request side (ports packed, hart p at slice p)
  logic [NumHarts-1:0]           host_req_i;
  logic [NumHarts-1:0]           host_gnt_o;
  logic [NumHarts-1:0]           host_we_i;
  logic [NumHarts-1:0]           host_is_cap_i;
  logic [4*NumHarts-1:0]         host_be_i;
  logic [32*NumHarts-1:0]        host_addr_i;
  logic [DataWidth*NumHarts-1:0] host_wdata_i;
  logic [NumHarts-1:0]           host_rvalid_o;
  logic [DataWidth-1:0]          host_rdata_o;
  logic [NumHarts-1:0]           host_err_o;

  // Shared memory port
  logic                          mem_req_o;
  logic                          mem_gnt_i;
  logic                          mem_we_o;
  logic                          mem_is_cap_o;
  logic [3:0]                    mem_be_o;
  logic [31:0]                   mem_addr_o;
  logic [DataWidth-1:0]          mem_wdata_o;
  logic                          mem_rvalid_i;
  logic [DataWidth-1:0]          mem_rdata_i;
  logic                          mem_err_i;

  // Arbiter view: accepts hart requests and drives the shared port
  modport slave (
    input  host_req_i, host_we_i, host_is_cap_i, host_be_i, host_addr_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    output mem_req_o, mem_we_o, mem_is_cap_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
  );

  // System view: the harts and the shared memory around the arbiter
  modport master (
    output host_req_i, host_we_i, host_is_cap_i, host_be_i, host_addr_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    input  mem_req_o, mem_we_o, mem_is_cap_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
  );
endinterface

// File: rtl/ibexc_dbus_arbiter.sv
// ibexc_dbus_arbiter: round-robin merge of NumHarts CHERIoT data ports onto one
// shared data port, with in-order response routing through an ID FIFO.
// Optional feature: define IBEXC_DBUS_CAP_LOCK_EN to keep both beats of a
// capability access on the same port back to back.
module ibexc_dbus_arbiter #(
  parameter int unsigned NumHarts       = 2,
  parameter int unsigned DataWidth      = 33,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  ibexc_dbus_arbiter_if.slave  bus,
  output logic [CntW-1:0]      outstanding_o,
  output logic                 rsp_unexpected_o
);

  localparam int unsigned IdxW = (NumHarts > 1) ? $clog2(NumHarts) : 1;
  localparam int unsigned PtrW = $clog2(MaxOutstanding);

  logic [IdxW-1:0]      rr_q;
  logic [IdxW-1:0]      sel;
  logic [IdxW-1:0]      sel_next;
  logic [IdxW:0]        cand;
  logic [31:0]          sel_w;
  logic                 any_req;
  logic                 full;
  logic                 mem_req;
  logic                 push;
  logic                 pop;

  logic [IdxW-1:0]      fifo_q [MaxOutstanding];
  logic [PtrW-1:0]      wr_ptr_q;
  logic [PtrW-1:0]      rd_ptr_q;
  logic [CntW-1:0]      cnt_q;
  logic [IdxW-1:0]      head;
  logic                 unexp_q;

  logic                 mem_we;
  logic                 mem_is_cap;
  logic [3:0]           mem_be;
  logic [31:0]          mem_addr;
  logic [DataWidth-1:0] mem_wdata;
  logic [NumHarts-1:0]  host_gnt;
  logic [NumHarts-1:0]  host_rvalid;
  logic [NumHarts-1:0]  host_err;

`ifdef IBEXC_DBUS_CAP_LOCK_EN
  typedef enum logic {LkFree = 1'b0, LkHeld = 1'b1} lock_e;
  lock_e lock_q;
`endif

  // Port selection: first requester at or after rr_q, wrapping; forced while locked
  always_comb begin
    any_req = 1'b0;
    sel     = rr_q;
    cand    = '0;
`ifdef IBEXC_DBUS_CAP_LOCK_EN
    if (lock_q == LkHeld) begin
      any_req = bus.host_req_i[rr_q];
    end else begin
`endif
      for (int unsigned k = 0; k < NumHarts; k++) begin
        cand = (IdxW+1)'(rr_q) + (IdxW+1)'(k);
        if (cand >= (IdxW+1)'(NumHarts)) begin
          cand = cand - (IdxW+1)'(NumHarts);
        end
        if (!any_req && bus.host_req_i[cand[IdxW-1:0]]) begin
          any_req = 1'b1;
          sel     = cand[IdxW-1:0];
        end
      end
`ifdef IBEXC_DBUS_CAP_LOCK_EN
    end
`endif
  end

  assign sel_w    = 32'(sel);
  assign sel_next = (sel == IdxW'(NumHarts - 1)) ? '0 : sel + IdxW'(1);

  // A pop in the same cycle does not free a slot for this cycle's request
  assign full    = (cnt_q == CntW'(MaxOutstanding));
  assign mem_req = any_req & ~full & ~rst_i;
  assign push    = mem_req & bus.mem_gnt_i;
  assign pop     = bus.mem_rvalid_i & (cnt_q != '0) & ~rst_i;
  assign head    = fifo_q[rd_ptr_q];

  // Forward the selected port's address/data phase; zero when idle
  always_comb begin
    mem_we     = 1'b0;
    mem_is_cap = 1'b0;
    mem_be     = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (any_req) begin
      mem_we     = bus.host_we_i[sel];
      mem_is_cap = bus.host_is_cap_i[sel];
      mem_be     = bus.host_be_i[sel_w*4 +: 4];
      mem_addr   = bus.host_addr_i[sel_w*32 +: 32];
      mem_wdata  = bus.host_wdata_i[sel_w*DataWidth +: DataWidth];
    end
  end

  // Grant goes to the selected port only; responses go to the FIFO head
  always_comb begin
    host_gnt    = '0;
    host_rvalid = '0;
    host_err    = '0;
    if (push) begin
      host_gnt[sel] = 1'b1;
    end
    if (pop) begin
      host_rvalid[head] = 1'b1;
      host_err[head]    = bus.mem_err_i;
    end
  end

  // ID FIFO storage: holds the port index of each granted transaction
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= sel;
    end
  end

  // FIFO pointers, occupancy and sticky unexpected-response flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      unexp_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + CntW'(1);
      end else if (!push && pop) begin
        cnt_q <= cnt_q - CntW'(1);
      end
      if (bus.mem_rvalid_i && (cnt_q == '0)) begin
        unexp_q <= 1'b1;
      end
    end
  end

`ifdef IBEXC_DBUS_CAP_LOCK_EN
  // Round-robin pointer and capability lock: a cap grant pins rr_q to its port
  // until the second cap beat is granted or the port abandons the access
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q   <= '0;
      lock_q <= LkFree;
    end else begin
      if (push) begin
        if (lock_q == LkHeld) begin
          if (mem_is_cap) begin
            lock_q <= LkFree;
            rr_q   <= sel_next;
          end
        end else if (mem_is_cap) begin
          lock_q <= LkHeld;
          rr_q   <= sel;
        end else begin
          rr_q <= sel_next;
        end
      end else if ((lock_q == LkHeld) && !bus.host_req_i[rr_q]) begin
        lock_q <= LkFree;
      end
    end
  end
`else
  // Round-robin pointer: next search starts after the granted port
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else if (push) begin
      rr_q <= sel_next;
    end
  end
`endif

  assign bus.mem_req_o     = mem_req;
  assign bus.mem_we_o      = mem_we;
  assign bus.mem_is_cap_o  = mem_is_cap;
  assign bus.mem_be_o      = mem_be;
  assign bus.mem_addr_o    = mem_addr;
  assign bus.mem_wdata_o   = mem_wdata;
  assign bus.host_gnt_o    = host_gnt;
  assign bus.host_rvalid_o = host_rvalid;
  assign bus.host_err_o    = host_err;
  assign bus.host_rdata_o  = bus.mem_rdata_i;
  assign outstanding_o     = cnt_q;
  assign rsp_unexpected_o  = unexp_q;

endmodule

// File: tb/tb_ibexc_dbus_arbiter.sv
// tb_ibexc_dbus_arbiter: directed scenarios with literal expectations followed
// by randomized OBI traffic, all checked every cycle against a queue-based model.
module tb_ibexc_dbus_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned DW = 33;
  localparam int unsigned MO = 4;

  logic       clk;
  logic       rst;
  logic [2:0] outstanding;
  logic       rsp_unexpected;

  ibexc_dbus_arbiter_if #(.NumHarts(N), .DataWidth(DW)) bus ();

  ibexc_dbus_arbiter #(
    .NumHarts(N), .DataWidth(DW), .MaxOutstanding(MO)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .bus             (bus),
    .outstanding_o   (outstanding),
    .rsp_unexpected_o(rsp_unexpected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: transaction queue of granted port numbers, rr start index
  int           m_q[$];
  int           m_rr;
  bit           m_unexp;
  bit           m_lock;
  logic [N-1:0] last_gnt;

  logic [N-1:0] e_gnt, e_rvalid, e_err;
  logic         e_found, e_req, e_we, e_cap;
  logic [3:0]   e_be;
  logic [31:0]  e_addr;
  logic [DW-1:0] e_wdata;
  int           e_sel;
  bit           e_empty;

  initial begin
    m_rr = 0; m_unexp = 0; m_lock = 0; last_gnt = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_gnt", 64'(bus.host_gnt_o), 64'(0));
        chk("rst_rvalid", 64'(bus.host_rvalid_o), 64'(0));
        chk("rst_err", 64'(bus.host_err_o), 64'(0));
        chk("rst_mem_req", 64'(bus.mem_req_o), 64'(0));
        chk("rst_outstanding", 64'(outstanding), 64'(0));
        chk("rst_unexpected", 64'(rsp_unexpected), 64'(0));
        m_q.delete();
        m_rr = 0; m_unexp = 0; m_lock = 0; last_gnt = '0;
      end else begin
        e_found = 1'b0;
        e_sel   = 0;
`ifdef IBEXC_DBUS_CAP_LOCK_EN
        if (m_lock) begin
          e_found = bus.host_req_i[m_rr];
          e_sel   = m_rr;
        end else
`endif
        for (int k = 0; k < N; k++) begin
          if (!e_found && bus.host_req_i[(m_rr + k) % N]) begin
            e_found = 1'b1;
            e_sel   = (m_rr + k) % N;
          end
        end
        e_req   = e_found && (m_q.size() < MO);
        e_we    = e_found ? bus.host_we_i[e_sel] : 1'b0;
        e_cap   = e_found ? bus.host_is_cap_i[e_sel] : 1'b0;
        e_be    = e_found ? bus.host_be_i[4*e_sel +: 4] : 4'h0;
        e_addr  = e_found ? bus.host_addr_i[32*e_sel +: 32] : 32'h0;
        e_wdata = e_found ? bus.host_wdata_i[DW*e_sel +: DW] : '0;
        e_gnt   = '0;
        if (e_req && bus.mem_gnt_i) e_gnt[e_sel] = 1'b1;
        e_empty  = (m_q.size() == 0);
        e_rvalid = '0;
        e_err    = '0;
        if (bus.mem_rvalid_i && !e_empty) begin
          e_rvalid[m_q[0]] = 1'b1;
          e_err[m_q[0]]    = bus.mem_err_i;
        end

        chk("mem_req", 64'(bus.mem_req_o), 64'(e_req));
        chk("host_gnt", 64'(bus.host_gnt_o), 64'(e_gnt));
        chk("mem_we", 64'(bus.mem_we_o), 64'(e_we));
        chk("mem_is_cap", 64'(bus.mem_is_cap_o), 64'(e_cap));
        chk("mem_be", 64'(bus.mem_be_o), 64'(e_be));
        chk("mem_addr", 64'(bus.mem_addr_o), 64'(e_addr));
        chk("mem_wdata", 64'(bus.mem_wdata_o), 64'(e_wdata));
        chk("host_rvalid", 64'(bus.host_rvalid_o), 64'(e_rvalid));
        chk("host_err", 64'(bus.host_err_o), 64'(e_err));
        chk("host_rdata", 64'(bus.host_rdata_o), 64'(bus.mem_rdata_i));
        chk("outstanding", 64'(outstanding), 64'(m_q.size()));
        chk("rsp_unexpected", 64'(rsp_unexpected), 64'(m_unexp));

        if (bus.mem_rvalid_i && e_empty) m_unexp = 1'b1;
        if (bus.mem_rvalid_i && !e_empty) void'(m_q.pop_front());
        if (e_gnt != '0) begin
          m_q.push_back(e_sel);
`ifdef IBEXC_DBUS_CAP_LOCK_EN
          if (m_lock) begin
            if (e_cap) begin m_lock = 1'b0; m_rr = (e_sel + 1) % N; end
          end else if (e_cap) begin
            m_lock = 1'b1; m_rr = e_sel;
          end else begin
            m_rr = (e_sel + 1) % N;
          end
        end else if (m_lock && !bus.host_req_i[m_rr]) begin
          m_lock = 1'b0;
`else
          m_rr = (e_sel + 1) % N;
`endif
        end
        last_gnt = e_gnt;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic at_check();
    @(negedge clk); #1;
  endtask

  task automatic idle();
    bus.host_req_i    = '0;
    bus.host_we_i     = '0;
    bus.host_is_cap_i = '0;
    bus.mem_gnt_i     = 1'b0;
    bus.mem_rvalid_i  = 1'b0;
    bus.mem_err_i     = 1'b0;
  endtask

  // One cycle of random OBI-legal traffic; ungranted requests hold their phase
  task automatic rand_cycle();
    step();
    for (int p = 0; p < N; p++) begin
      if (!(bus.host_req_i[p] && !last_gnt[p])) begin
        bus.host_req_i[p]            = ($urandom % 8) < 5;
        bus.host_we_i[p]             = 1'($urandom % 2);
        bus.host_is_cap_i[p]         = ($urandom % 4) == 0;
        bus.host_be_i[4*p +: 4]      = 4'($urandom);
        bus.host_addr_i[32*p +: 32]  = $urandom;
        bus.host_wdata_i[DW*p +: DW] = {1'($urandom % 2), 32'($urandom)};
      end
    end
    bus.mem_gnt_i    = ($urandom % 4) != 0;
    bus.mem_rvalid_i = !rst && (m_q.size() > 0) && (($urandom % 3) != 0);
    bus.mem_err_i    = ($urandom % 8) == 0;
    bus.mem_rdata_i  = {1'($urandom % 2), 32'($urandom)};
  endtask

  logic [1:0] exp_g [3];

  initial begin
    rst = 1'b1;
    idle();
    bus.host_be_i    = '0;
    bus.host_addr_i  = '0;
    bus.host_wdata_i = '0;
    bus.mem_rdata_i  = '0;
    bus.host_req_i   = 2'b11;
    at_check();
    chk("lit_reset_mem_req", 64'(bus.mem_req_o), 64'(0));
    chk("lit_reset_gnt", 64'(bus.host_gnt_o), 64'(0));
    chk("lit_reset_outstanding", 64'(outstanding), 64'(0));
    step();
    rst = 1'b0;
    idle();

    // Single hart 0 load with next-cycle response
    step();
    bus.host_req_i = 2'b01; bus.host_addr_i[31:0] = 32'h0000_1000; bus.mem_gnt_i = 1'b1;
    at_check();
    chk("lit_load_gnt", 64'(bus.host_gnt_o), 64'h1);
    chk("lit_load_addr", 64'(bus.mem_addr_o), 64'h1000);
    chk("lit_load_outst0", 64'(outstanding), 64'(0));
    step();
    idle(); bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 33'h1_DEAD_BEEF;
    at_check();
    chk("lit_load_rvalid", 64'(bus.host_rvalid_o), 64'h1);
    chk("lit_load_rdata", 64'(bus.host_rdata_o), 64'h1_DEAD_BEEF);
    chk("lit_load_outst1", 64'(outstanding), 64'(1));
    step();
    idle();
    at_check();
    chk("lit_load_outst_done", 64'(outstanding), 64'(0));

    // Both ports requesting: grants alternate, responses follow grant order
    exp_g = '{2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 3; i++) begin
      step();
      bus.host_req_i = 2'b11; bus.mem_gnt_i = 1'b1;
      at_check();
      chk("lit_rr_gnt", 64'(bus.host_gnt_o), 64'(exp_g[i]));
    end
    for (int i = 0; i < 3; i++) begin
      step();
      idle(); bus.mem_rvalid_i = 1'b1; bus.mem_err_i = (i == 0);
      at_check();
      chk("lit_rr_rvalid", 64'(bus.host_rvalid_o), 64'(exp_g[i]));
      chk("lit_rr_err", 64'(bus.host_err_o), (i == 0) ? 64'h2 : 64'h0);
    end

    // Fill to MaxOutstanding, then one response frees a slot
    for (int i = 0; i < 4; i++) begin
      step();
      idle(); bus.host_req_i = 2'b01; bus.mem_gnt_i = 1'b1;
      at_check();
      chk("lit_fill_gnt", 64'(bus.host_gnt_o), 64'h1);
    end
    step();
    bus.mem_rvalid_i = 1'b1;
    at_check();
    chk("lit_full_outst", 64'(outstanding), 64'(4));
    chk("lit_full_mem_req", 64'(bus.mem_req_o), 64'(0));
    chk("lit_full_gnt", 64'(bus.host_gnt_o), 64'(0));
    step();
    bus.mem_rvalid_i = 1'b0; bus.mem_gnt_i = 1'b0;
    at_check();
    chk("lit_free_outst", 64'(outstanding), 64'(3));
    chk("lit_free_mem_req", 64'(bus.mem_req_o), 64'(1));
    for (int i = 0; i < 3; i++) begin
      step();
      idle(); bus.mem_rvalid_i = 1'b1;
    end
    step();
    idle();
    at_check();
    chk("lit_drain_outst", 64'(outstanding), 64'(0));

    // Response with empty FIFO: dropped, sticky flag set
    step();
    bus.mem_rvalid_i = 1'b1;
    at_check();
    chk("lit_unexp_rvalid", 64'(bus.host_rvalid_o), 64'(0));
    step();
    idle();
    at_check();
    chk("lit_unexp_set", 64'(rsp_unexpected), 64'(1));
    step();
    at_check();
    chk("lit_unexp_held", 64'(rsp_unexpected), 64'(1));

    // Reset with two transactions in flight
    for (int i = 0; i < 2; i++) begin
      step();
      bus.host_req_i = 2'b01; bus.mem_gnt_i = 1'b1;
    end
    step();
    idle();
    at_check();
    chk("lit_pre_rst_outst", 64'(outstanding), 64'(2));
    step();
    rst = 1'b1;
    at_check();
    chk("lit_mid_rst_outst", 64'(outstanding), 64'(0));
    chk("lit_mid_rst_unexp", 64'(rsp_unexpected), 64'(0));
    step();
    rst = 1'b0;

    // Two-beat capability store on port 0 while port 1 requests
`ifdef IBEXC_DBUS_CAP_LOCK_EN
    exp_g = '{2'b01, 2'b01, 2'b10};
`else
    exp_g = '{2'b01, 2'b10, 2'b01};
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      bus.mem_gnt_i = 1'b1;
      bus.host_is_cap_i = 2'b01;
`ifdef IBEXC_DBUS_CAP_LOCK_EN
      bus.host_req_i = (i < 2) ? 2'b11 : 2'b10;
`else
      bus.host_req_i = (i < 2) ? 2'b11 : 2'b01;
`endif
      at_check();
      chk("lit_cap_gnt", 64'(bus.host_gnt_o), 64'(exp_g[i]));
    end
    for (int i = 0; i < 3; i++) begin
      step();
      idle(); bus.mem_rvalid_i = 1'b1;
      at_check();
      chk("lit_cap_rvalid", 64'(bus.host_rvalid_o), 64'(exp_g[i]));
    end
    step();
    idle();

    // Randomized traffic with one reset in the middle
    for (int c = 0; c < 3000; c++) begin
      rand_cycle();
      if (c == 1500) begin
        rst = 1'b1; bus.mem_rvalid_i = 1'b0;
      end else if (c == 1501) begin
        rst = 1'b0;
      end
    end

    // Drain remaining responses
    step();
    idle();
    for (int c = 0; c < 20 && m_q.size() > 0; c++) begin
      bus.mem_rvalid_i = 1'b1;
      step();
    end
    idle();
    at_check();
    chk("final_outstanding", 64'(outstanding), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
